// File: rtl/ram_request_responder.sv
// Data-memory responder for the I/S/A/F RAM request channels: fixed-priority
// arbitration, one access in flight, registered per-channel read data and ack.
module ram_request_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCE_I,
  input  logic              iRD_I,
  input  logic              iWR_I,
  input  logic [ADDR_W-1:0] iADDR_I,
  input  logic [DATA_W-1:0] iDATA_WR_I,
  input  logic              iCE_S,
  input  logic              iRD_S,
  input  logic              iWR_S,
  input  logic [ADDR_W-1:0] iADDR_S,
  input  logic [DATA_W-1:0] iDATA_WR_S,
  input  logic              iCE_A,
  input  logic              iRD_A,
  input  logic              iWR_A,
  input  logic [ADDR_W-1:0] iADDR_A,
  input  logic [DATA_W-1:0] iDATA_WR_A,
  input  logic              iCE_F,
  input  logic              iRD_F,
  input  logic              iWR_F,
  input  logic [ADDR_W-1:0] iADDR_F,
  input  logic [DATA_W-1:0] iDATA_WR_F,
  output logic [DATA_W-1:0] oDATA_RD_I,
  output logic [DATA_W-1:0] oDATA_RD_S,
  output logic [DATA_W-1:0] oDATA_RD_A,
  output logic [DATA_W-1:0] oDATA_RD_F,
  output logic              oACK_I,
  output logic              oACK_S,
  output logic              oACK_A,
  output logic              oACK_F,
  output logic              oBUSY
);

  localparam int unsigned NCH  = 4;
  localparam int unsigned CH_W = 2;
  localparam logic [CH_W-1:0] CH_I = CH_W'(0);
  localparam logic [CH_W-1:0] CH_S = CH_W'(1);
  localparam logic [CH_W-1:0] CH_A = CH_W'(2);
  localparam logic [CH_W-1:0] CH_F = CH_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    RMW  = 2'd2
  } state_t;

  logic [NCH-1:0]    ce, rd, wr, valid;
  logic [ADDR_W-1:0] addr  [NCH];
  logic [DATA_W-1:0] wdata [NCH];

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, gnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [NCH-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q [NCH];
  logic [DATA_W-1:0] rdata_d [NCH];
  logic              busy_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Channel bundles indexed by CH_* so arbitration is a plain lookup
  assign ce = {iCE_F, iCE_A, iCE_S, iCE_I};
  assign rd = {iRD_F, iRD_A, iRD_S, iRD_I};
  assign wr = {iWR_F, iWR_A, iWR_S, iWR_I};
  assign addr[CH_I]  = iADDR_I;
  assign addr[CH_S]  = iADDR_S;
  assign addr[CH_A]  = iADDR_A;
  assign addr[CH_F]  = iADDR_F;
  assign wdata[CH_I] = iDATA_WR_I;
  assign wdata[CH_S] = iDATA_WR_S;
  assign wdata[CH_A] = iDATA_WR_A;
  assign wdata[CH_F] = iDATA_WR_F;

  // Arbitration, next state and next registered outputs
  always_comb begin
    valid     = ce & (rd | wr);
    gnt       = CH_I;
    state_d   = state_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    old_d     = old_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;

    if (valid[CH_A])      gnt = CH_A;
    else if (valid[CH_S]) gnt = CH_S;
    else if (valid[CH_F]) gnt = CH_F;

    case (state_q)
      IDLE: begin
        if (|valid) begin
          ch_d    = gnt;
          addr_d  = addr[gnt];
          wdata_d = wdata[gnt];
          if (gnt == CH_A && rd[gnt] && wr[gnt]) begin
            old_d   = mem[addr[gnt]];
            state_d = RMW;
          end else begin
            state_d    = ACK;
            ack_d[gnt] = 1'b1;
            // RD wins when both are set on a non-atomic channel
            if (rd[gnt]) begin
              rdata_d[gnt] = mem[addr[gnt]];
            end else begin
              mem_we    = 1'b1;
              mem_waddr = addr[gnt];
              mem_wdata = wdata[gnt];
            end
          end
        end
      end
      RMW: begin
        mem_we        = 1'b1;
        ack_d[ch_q]   = 1'b1;
        rdata_d[ch_q] = old_q;
        state_d       = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      ch_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '{default: '0};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Memory is never cleared; reset only blocks a write in the same cycle
  always_ff @(posedge iCLK) begin
    if (mem_we && !iRST) mem[mem_waddr] <= mem_wdata;
  end

  assign oDATA_RD_I = rdata_q[CH_I];
  assign oDATA_RD_S = rdata_q[CH_S];
  assign oDATA_RD_A = rdata_q[CH_A];
  assign oDATA_RD_F = rdata_q[CH_F];
  assign oACK_I     = ack_q[CH_I];
  assign oACK_S     = ack_q[CH_S];
  assign oACK_A     = ack_q[CH_A];
  assign oACK_F     = ack_q[CH_F];
  assign oBUSY      = busy_q;

endmodule

// File: tb/tb_ram_request_responder.sv
// Directed bench for ram_request_responder: transaction-level model checked
// every cycle, plus literal expectations for each scenario.
module tb_ram_request_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce [4];
  logic        rd [4];
  logic        wr [4];
  logic [7:0]  ad [4];
  logic [31:0] wd [4];

  logic [31:0] dr [4];
  logic [3:0]  ack;
  logic        busy;

  int vecs = 0;
  int errs = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  ram_request_responder dut (
    .iCLK(clk), .iRST(rst),
    .iCE_I(ce[0]), .iRD_I(rd[0]), .iWR_I(wr[0]), .iADDR_I(ad[0]), .iDATA_WR_I(wd[0]),
    .iCE_S(ce[1]), .iRD_S(rd[1]), .iWR_S(wr[1]), .iADDR_S(ad[1]), .iDATA_WR_S(wd[1]),
    .iCE_A(ce[2]), .iRD_A(rd[2]), .iWR_A(wr[2]), .iADDR_A(ad[2]), .iDATA_WR_A(wd[2]),
    .iCE_F(ce[3]), .iRD_F(rd[3]), .iWR_F(wr[3]), .iADDR_F(ad[3]), .iDATA_WR_F(wd[3]),
    .oDATA_RD_I(dr[0]), .oDATA_RD_S(dr[1]), .oDATA_RD_A(dr[2]), .oDATA_RD_F(dr[3]),
    .oACK_I(ack[0]), .oACK_S(ack[1]), .oACK_A(ack[2]), .oACK_F(ack[3]),
    .oBUSY(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: channels 0..3 = I,S,A,F; priority A > S > F > I
  logic [31:0] mmem [256];
  logic [31:0] m_data [4];
  logic [3:0]  m_ack = '0;
  bit          m_busy = 1'b0;
  int          busy_left = 0;
  bit          swap_pend = 1'b0;
  logic [7:0]  s_addr;
  logic [31:0] s_wd, s_old;
  int          pri [4] = '{2, 1, 3, 0};

  always @(posedge clk) begin
    int g;
    m_ack = '0;
    if (rst) begin
      busy_left = 0;
      swap_pend = 1'b0;
      for (int k = 0; k < 4; k++) m_data[k] = '0;
    end else if (busy_left > 0) begin
      if (swap_pend && busy_left == 2) begin
        mmem[s_addr] = s_wd;
        m_ack[2]     = 1'b1;
        m_data[2]    = s_old;
        swap_pend    = 1'b0;
      end
      busy_left--;
    end else begin
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && ce[pri[k]] && (rd[pri[k]] || wr[pri[k]])) g = pri[k];
      if (g == 2 && rd[2] && wr[2]) begin
        swap_pend = 1'b1;
        s_addr    = ad[2];
        s_wd      = wd[2];
        s_old     = mmem[ad[2]];
        busy_left = 2;
      end else if (g >= 0) begin
        m_ack[g]  = 1'b1;
        busy_left = 1;
        if (rd[g]) m_data[g] = mmem[ad[g]];
        else       mmem[ad[g]] = wd[g];
      end
    end
    m_busy = (busy_left > 0);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      check("ack", 32'(ack), 32'(m_ack));
      check("busy", 32'(busy), 32'(m_busy));
      check("data_I", dr[0], m_data[0]);
      check("data_S", dr[1], m_data[1]);
      check("data_A", dr[2], m_data[2]);
      check("data_F", dr[3], m_data[3]);
    end
  end

  int ack_at [4];
  int busy_cnt;

  task automatic req(input int c, input bit r, input bit w, input logic [7:0] a, input logic [31:0] d);
    ce[c] = 1'b1; rd[c] = r; wr[c] = w; ad[c] = a; wd[c] = d;
  endtask

  task automatic drop(input int c);
    ce[c] = 1'b0; rd[c] = 1'b0; wr[c] = 1'b0;
  endtask

  // Runs from the current negedge until every request is acked and the DUT is idle
  task automatic run(input int max_cyc);
    bit done;
    busy_cnt = 0;
    done = 1'b0;
    for (int k = 0; k < 4; k++) ack_at[k] = -1;
    for (int i = 1; i <= max_cyc && !done; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      for (int k = 0; k < 4; k++)
        if (ack[k]) begin
          ack_at[k] = i;
          drop(k);
        end
      done = !busy && !ce[0] && !ce[1] && !ce[2] && !ce[3];
    end
    if (!done) begin
      vecs++;
      errs++;
      $display("FAIL run_timeout: got pending requests expected all acked within %0d cycles", max_cyc);
      for (int k = 0; k < 4; k++) drop(k);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      drop(k); ad[k] = '0; wd[k] = '0;
    end
    for (int k = 0; k < 256; k++) mmem[k] = '0;
    @(posedge clk);
    checking = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data_I", dr[0], 32'h0);

    // T1: store then load
    req(1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    run(10);
    check("t1_ack_S_lat", 32'(ack_at[1]), 32'd1);
    req(0, 1'b1, 1'b0, 8'h10, 32'h0);
    run(10);
    check("t1_ack_I_lat", 32'(ack_at[0]), 32'd1);
    check("t1_data_I", dr[0], 32'hDEADBEEF);

    // T2: simultaneous I read and S write to same address
    req(0, 1'b1, 1'b0, 8'h01, 32'h0);
    req(1, 1'b0, 1'b1, 8'h01, 32'h55);
    run(10);
    check("t2_ack_S_lat", 32'(ack_at[1]), 32'd1);
    check("t2_ack_I_lat", 32'(ack_at[0]), 32'd3);
    check("t2_data_I", dr[0], 32'h55);

    // T3: swap on channel A
    req(1, 1'b0, 1'b1, 8'h20, 32'd7);
    run(10);
    req(2, 1'b1, 1'b1, 8'h20, 32'd9);
    run(10);
    check("t3_busy_cycles", 32'(busy_cnt), 32'd2);
    check("t3_ack_A_lat", 32'(ack_at[2]), 32'd2);
    check("t3_data_A", dr[2], 32'd7);
    req(0, 1'b1, 1'b0, 8'h20, 32'h0);
    run(10);
    check("t3_readback", dr[0], 32'd9);

    // T4: swap interrupted by reset in the RMW cycle
    req(1, 1'b0, 1'b1, 8'h20, 32'd7);
    run(10);
    req(2, 1'b1, 1'b1, 8'h20, 32'd9);
    @(negedge clk);
    check("t4_rmw_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    drop(2);
    @(negedge clk);
    rst = 1'b0;
    check("t4_ack", 32'(ack), 32'h0);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_data_A", dr[2], 32'h0);
    check("t4_data_I", dr[0], 32'h0);
    req(0, 1'b1, 1'b0, 8'h20, 32'h0);
    run(10);
    check("t4_mem_kept", dr[0], 32'd7);

    // T5: enable without RD/WR is ignored; then top address write/read
    req(3, 1'b0, 1'b0, 8'hFF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_idle_busy", 32'(busy), 32'h0);
      check("t5_idle_ack", 32'(ack), 32'h0);
    end
    drop(3);
    req(3, 1'b0, 1'b1, 8'hFF, 32'hA5A5A5A5);
    run(10);
    req(3, 1'b1, 1'b0, 8'hFF, 32'h0);
    run(10);
    check("t5_readback", dr[3], 32'hA5A5A5A5);

    // T6: I read data held while other channels work
    req(1, 1'b0, 1'b1, 8'h30, 32'h1234);
    run(10);
    req(0, 1'b1, 1'b0, 8'h30, 32'h0);
    run(10);
    check("t6_data_I", dr[0], 32'h1234);
    req(1, 1'b0, 1'b1, 8'h31, 32'hCAFE);
    req(3, 1'b1, 1'b0, 8'h30, 32'h0);
    run(10);
    check("t6_ack_I_none", 32'(ack_at[0]), 32'hFFFFFFFF);
    check("t6_data_I_held", dr[0], 32'h1234);
    check("t6_data_F", dr[3], 32'h1234);

    // Priority with all four requesting: A, S, F, I order
    req(0, 1'b1, 1'b0, 8'h31, 32'h0);
    req(1, 1'b1, 1'b0, 8'h10, 32'h0);
    req(2, 1'b1, 1'b0, 8'h01, 32'h0);
    req(3, 1'b1, 1'b1, 8'hFF, 32'h0);
    run(20);
    check("pri_A", 32'(ack_at[2]), 32'd1);
    check("pri_S", 32'(ack_at[1]), 32'd3);
    check("pri_F", 32'(ack_at[3]), 32'd5);
    check("pri_I", 32'(ack_at[0]), 32'd7);
    check("pri_data_I", dr[0], 32'hCAFE);
    check("pri_data_F", dr[3], 32'hA5A5A5A5);

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
